// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM encoding and
// bit-counter sizing.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;
    localparam int CNT_W         = $clog2(DEFAULT_WIDTH);

    // Counter width for a given operand width; never below one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor cell: difference and borrow-out of a - b - bin.
module FullSubtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic difference,
    output logic borrow
);

    assign difference = a ^ b ^ bin;
    assign borrow     = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one bit per clock through a single
// full-subtractor cell, with a start/busy/done handshake.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] difference,
    output logic             borrow,
    output logic             overflow
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, b_sr_q, res_sr_q, diff_q;
    logic             br_q, borrow_q, ovf_q;
    logic [CW-1:0]    cnt_q;
    logic             cell_d, cell_br;
    logic             last_bit, accept;

    FullSubtractor u_cell (
        .a          (a_sr_q[0]),
        .b          (b_sr_q[0]),
        .bin        (br_q),
        .difference (cell_d),
        .borrow     (cell_br)
    );

    assign last_bit = (cnt_q == CW'(WIDTH - 1));
    // New work is taken in IDLE and in DONE (back-to-back), never mid-RUN.
    assign accept   = start && (state_q != RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (accept) begin
            a_sr_q <= a;
            b_sr_q <= b;
            br_q   <= bin;
            cnt_q  <= '0;
        end else if (state_q == RUN) begin
            a_sr_q   <= a_sr_q >> 1;
            b_sr_q   <= b_sr_q >> 1;
            res_sr_q <= {cell_d, res_sr_q[WIDTH-1:1]};
            br_q     <= cell_br;
            // Counter holds on the final bit so it never wraps.
            if (!last_bit) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                diff_q   <= {cell_d, res_sr_q[WIDTH-1:1]};
                borrow_q <= cell_br;
                ovf_q    <= br_q ^ cell_br;
            end
        end
    end

    assign difference = diff_q;
    assign borrow     = borrow_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed WIDTH=8 vectors plus an
// exhaustive WIDTH=2 sweep against an arithmetic reference.
module tb_serial_subtractor;

    typedef struct {
        logic [7:0] d;
        logic       br;
        logic       ov;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    logic       start8, bin8, busy8, done8, br8, ov8;
    logic [7:0] a8, b8, diff8;
    logic       start2, bin2, busy2, done2, br2, ov2;
    logic [1:0] a2, b2, diff2;

    exp_t q8[$];
    exp_t q2[$];
    exp_t e8, e2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .difference(diff8), .borrow(br8), .overflow(ov8)
    );

    serial_subtractor #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .bin(bin2),
        .busy(busy2), .done(done2), .difference(diff2), .borrow(br2), .overflow(ov2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitors: pop the next expectation whenever a done pulse appears.
    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            chk("busy_with_done8", {31'd0, busy8}, 32'd0);
            if (q8.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done8 actual=done required=no done (cycle %0d)", cyc);
            end else begin
                e8 = q8.pop_front();
                chk("difference8", {24'd0, diff8}, {24'd0, e8.d});
                chk("borrow8", {31'd0, br8}, {31'd0, e8.br});
                chk("overflow8", {31'd0, ov8}, {31'd0, e8.ov});
                chk("latency8", cyc, e8.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (done2 === 1'b1) begin
            chk("busy_with_done2", {31'd0, busy2}, 32'd0);
            if (q2.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done2 actual=done required=no done (cycle %0d)", cyc);
            end else begin
                e2 = q2.pop_front();
                chk("difference2", {30'd0, diff2}, {24'd0, e2.d});
                chk("borrow2", {31'd0, br2}, {31'd0, e2.br});
                chk("overflow2", {31'd0, ov2}, {31'd0, e2.ov});
                chk("latency2", cyc, e2.cyc);
            end
        end
    end

    // Called just after a falling edge; start is held for one rising edge.
    task automatic send8(input logic [7:0] av, input logic [7:0] bv, input logic ci,
                         input logic [7:0] ed, input logic eb, input logic eo,
                         input bit expect_it);
        exp_t e;
        start8 = 1'b1;
        a8     = av;
        b8     = bv;
        bin8   = ci;
        if (expect_it) begin
            e.d   = ed;
            e.br  = eb;
            e.ov  = eo;
            e.cyc = cyc + 1 + 8;
            q8.push_back(e);
        end
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic send2(input logic [1:0] av, input logic [1:0] bv, input logic ci,
                         input logic [1:0] ed, input logic eb, input logic eo);
        exp_t e;
        start2 = 1'b1;
        a2     = av;
        b2     = bv;
        bin2   = ci;
        e.d    = {6'd0, ed};
        e.br   = eb;
        e.ov   = eo;
        e.cyc  = cyc + 1 + 2;
        q2.push_back(e);
        @(negedge clk);
        start2 = 1'b0;
    endtask

    task automatic drain8(input string nm);
        for (int i = 0; i < 40 && q8.size() != 0; i++) @(negedge clk);
        chk(nm, q8.size(), 32'd0);
        @(negedge clk);
    endtask

    task automatic drain2(input string nm);
        for (int i = 0; i < 20 && q2.size() != 0; i++) @(negedge clk);
        chk(nm, q2.size(), 32'd0);
        @(negedge clk);
    endtask

    // Directed WIDTH=8 vectors: a, b, bin, expected difference, borrow, overflow.
    logic [7:0] va  [5] = '{8'h05, 8'h03, 8'h00, 8'h80, 8'h7F};
    logic [7:0] vb  [5] = '{8'h03, 8'h05, 8'h00, 8'h01, 8'hFF};
    logic       vc  [5] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0};
    logic [7:0] vd  [5] = '{8'h02, 8'hFE, 8'hFF, 8'h7F, 8'h80};
    logic       vbr [5] = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b1};
    logic       vov [5] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1};

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int full, sa, sb, sdiff;
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        start2 = 1'b0; a2 = '0; b2 = '0; bin2 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("reset_busy8", {31'd0, busy8}, 32'd0);
        chk("reset_done8", {31'd0, done8}, 32'd0);
        chk("reset_diff8", {24'd0, diff8}, 32'd0);
        chk("reset_borrow8", {31'd0, br8}, 32'd0);
        chk("reset_overflow8", {31'd0, ov8}, 32'd0);
        chk("reset_busy2", {31'd0, busy2}, 32'd0);

        for (int i = 0; i < 5; i++) begin
            send8(va[i], vb[i], vc[i], vd[i], vbr[i], vov[i], 1'b1);
            chk("busy_after_accept8", {31'd0, busy8}, 32'd1);
            drain8("drain_vector8");
        end

        // Start during RUN is dropped; start during DONE chains straight on.
        send8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h11; b8 = 8'h00; bin8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        for (int i = 0; i < 20 && done8 !== 1'b1; i++) @(negedge clk);
        chk("reach_done8", {31'd0, done8}, 32'd1);
        send8(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b1);
        chk("busy_after_b2b8", {31'd0, busy8}, 32'd1);
        drain8("drain_b2b8");

        // Abort in the fourth RUN cycle: outputs clear and no done follows.
        send8(8'h05, 8'h03, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy8", {31'd0, busy8}, 32'd0);
        chk("abort_done8", {31'd0, done8}, 32'd0);
        chk("abort_diff8", {24'd0, diff8}, 32'd0);
        chk("abort_borrow8", {31'd0, br8}, 32'd0);
        chk("abort_overflow8", {31'd0, ov8}, 32'd0);
        repeat (10) @(negedge clk);
        send8(8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0, 1'b1);
        drain8("drain_after_abort8");

        // Exhaustive WIDTH=2 sweep against modulo-4 arithmetic.
        for (int av = 0; av < 4; av++) begin
            for (int bv = 0; bv < 4; bv++) begin
                for (int ci = 0; ci < 2; ci++) begin
                    full  = av - bv - ci;
                    sa    = (av >= 2) ? av - 4 : av;
                    sb    = (bv >= 2) ? bv - 4 : bv;
                    sdiff = sa - sb - ci;
                    send2(2'(av), 2'(bv), 1'(ci), 2'(full & 3), (full < 0),
                          (sdiff < -2) || (sdiff > 1));
                    drain2("drain_exh2");
                end
            end
        end

        chk("queue8_empty", q8.size(), 32'd0);
        chk("queue2_empty", q2.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
